// File: rtl/fram_req_scheduler.sv
// Request FIFO and one-at-a-time sequencer in front of the FM24CLxx FRAM driver.
// Holds the driver command stable per transaction and returns one response per request.
module fram_req_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1048576
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [7:0]               req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_write,
  output logic [7:0]               rsp_addr,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_timeout,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     drv_start,
  output logic [7:0]               drv_mem_address,
  output logic [31:0]              drv_data_in,
  output logic                     drv_write_enable,
  output logic                     drv_read_enable,
  input  logic                     drv_busy,
  input  logic [31:0]              drv_data_out,
  input  logic                     drv_rd_strobe
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT) + 1;

  // Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1;
  // valid never waits on ready, and a response holds all fields until accepted.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               wen_q, wen_d;
  logic               ren_q, ren_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               timeout_q, timeout_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;

  logic [40:0]        fifo_mem [DEPTH];
  logic [40:0]        head;
  logic               push;
  logic               pop;
  logic               wdog_hit;

  assign req_ready = (count_q != CNT_W'(DEPTH));
  assign push      = req_valid & req_ready;
  assign pop       = (state_q == ST_IDLE) && (count_q != '0);
  assign head      = fifo_mem[rd_ptr_q];
  assign wdog_hit  = (wdog_q == WD_W'(TIMEOUT - 1));

  // Payload storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {req_write, req_addr, req_wdata};
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wen_d     = wen_q;
    ren_d     = ren_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    wdog_d    = wdog_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          wen_d     = head[40];
          ren_d     = !head[40];
          addr_d    = head[39:32];
          wdata_d   = head[31:0];
          rdata_d   = '0;
          timeout_d = 1'b0;
          wdog_d    = '0;
          state_d   = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wdog_d = wdog_q + WD_W'(1);
        if (wdog_hit) begin
          timeout_d = 1'b1;
          rdata_d   = '0;
          state_d   = ST_RESP;
        end else if (drv_busy) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        wdog_d = wdog_q + WD_W'(1);
        if (drv_rd_strobe && ren_q) begin
          rdata_d = drv_data_out;
        end
        // A normal completion wins over a watchdog expiry in the same cycle.
        if (!drv_busy) begin
          timeout_d = 1'b0;
          state_d   = ST_RESP;
        end else if (wdog_hit) begin
          timeout_d = 1'b1;
          rdata_d   = '0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      wdog_q    <= wdog_d;
    end
  end

  assign drv_start        = (state_q == ST_LAUNCH);
  assign rsp_valid        = (state_q == ST_RESP);
  assign pending          = count_q;
  assign drv_mem_address  = addr_q;
  assign drv_data_in      = wdata_q;
  assign drv_write_enable = wen_q;
  assign drv_read_enable  = ren_q;
  assign rsp_write        = wen_q;
  assign rsp_addr         = addr_q;
  assign rsp_rdata        = rdata_q;
  assign rsp_timeout      = timeout_q;

endmodule

// File: tb/tb_fram_req_scheduler.sv
// Directed bench for fram_req_scheduler with a behavioural FRAM driver model
// (busy two cycles after start, optional one-cycle read strobe, optional hang).
module tb_fram_req_scheduler;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_write;
  logic [7:0]  rsp_addr;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic [2:0]  pending;
  logic        drv_start;
  logic [7:0]  drv_mem_address;
  logic [31:0] drv_data_in;
  logic        drv_write_enable;
  logic        drv_read_enable;
  logic        drv_busy;
  logic [31:0] drv_data_out;
  logic        drv_rd_strobe;

  fram_req_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .pending(pending),
    .drv_start(drv_start), .drv_mem_address(drv_mem_address), .drv_data_in(drv_data_in),
    .drv_write_enable(drv_write_enable), .drv_read_enable(drv_read_enable),
    .drv_busy(drv_busy), .drv_data_out(drv_data_out), .drv_rd_strobe(drv_rd_strobe)
  );

  // driver model
  int   busy_len = 40;
  logic hang     = 1'b0;
  int   m_st;
  int   m_cnt;

  function automatic logic [31:0] mdl_rdata(input logic [7:0] a);
    return (a == 8'h34) ? 32'hCAFEF00D : {16'hD00D, a, ~a};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st <= 0; m_cnt <= 0;
      drv_busy <= 1'b0; drv_rd_strobe <= 1'b0; drv_data_out <= '0;
    end else begin
      drv_rd_strobe <= 1'b0;
      drv_data_out  <= '0;
      case (m_st)
        0: if (drv_start) m_st <= 1;
        1: m_st <= 2;
        2: begin drv_busy <= 1'b1; m_cnt <= busy_len; m_st <= 3; end
        default: if (!hang) begin
          if (m_cnt == 2 && drv_read_enable) begin
            drv_rd_strobe <= 1'b1;
            drv_data_out  <= mdl_rdata(drv_mem_address);
          end
          if (m_cnt <= 1) begin drv_busy <= 1'b0; m_st <= 0; end
          else m_cnt <= m_cnt - 1;
        end
      endcase
    end
  end

  // scoreboard: {write, addr, rdata, timeout}
  logic [41:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic w, input logic [7:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic check_rsp();
    logic [41:0] e;
    if (exp_q.size() == 0) begin
      chk("rsp_unexpected", 32'(rsp_valid), 0);
    end else begin
      e = exp_q.pop_front();
      chk("rsp_write",   32'(rsp_write),   32'(e[41]));
      chk("rsp_addr",    32'(rsp_addr),    32'(e[40:33]));
      chk("rsp_rdata",   rsp_rdata,        e[32:1]);
      chk("rsp_timeout", 32'(rsp_timeout), 32'(e[0]));
    end
  endtask

  // Waits for rsp_valid; reports launch-to-response latency, command instability,
  // start/busy overlap samples and further start rises seen on the way.
  task automatic get_rsp(input int max_cyc, output int lat, output int unstable,
                         output int overlap, output int rises);
    logic        snap, found, prev_start;
    logic [7:0]  s_addr;
    logic [31:0] s_data;
    logic        s_we, s_re;
    int          snap_idx;
    snap = 1'b0; found = 1'b0; lat = -1; unstable = 0; overlap = 0; rises = 0;
    snap_idx = 0; s_addr = '0; s_data = '0; s_we = 1'b0; s_re = 1'b0;
    prev_start = drv_start;
    if (drv_start) begin
      snap = 1'b1; s_addr = drv_mem_address; s_data = drv_data_in;
      s_we = drv_write_enable; s_re = drv_read_enable;
      if (drv_busy) overlap++;
    end
    for (int i = 1; i <= max_cyc && !found; i++) begin
      tick();
      if (drv_start && !prev_start) rises++;
      prev_start = drv_start;
      if (drv_start && drv_busy) overlap++;
      if (drv_start && !snap) begin
        snap = 1'b1; snap_idx = i; s_addr = drv_mem_address; s_data = drv_data_in;
        s_we = drv_write_enable; s_re = drv_read_enable;
      end else if (snap && (drv_mem_address !== s_addr || drv_data_in !== s_data ||
                            drv_write_enable !== s_we || drv_read_enable !== s_re)) begin
        unstable++;
      end
      if (rsp_valid) begin
        found = 1'b1;
        lat = snap ? i - snap_idx : -1;
      end
    end
    chk("rsp_arrived", 32'(found), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, observed running expected done");
    $fatal(1, "global timeout");
  end

  int lat, unst, ovl, rises, bad_fields, starts_seen, rsp_seen;
  logic found_busy;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_pending",   32'(pending),   0);
    chk("rst_drv_start", 32'(drv_start), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_addr",      32'(drv_mem_address), 0);
    chk("rst_we_re",     32'({drv_write_enable, drv_read_enable}), 0);
    chk("rst_rdata",     rsp_rdata, 0);
    rst = 1'b0;
    tick();

    // single write, 40-cycle busy
    busy_len = 40;
    push(1'b1, 8'h12, 32'hDEADBEEF);
    exp_q.push_back({1'b1, 8'h12, 32'h0, 1'b0});
    chk("w_pending_after_push", 32'(pending), 1);
    chk("w_no_start_yet", 32'(drv_start), 0);
    tick();
    chk("w_launch_start", 32'(drv_start), 1);
    chk("w_addr",  32'(drv_mem_address), 32'h12);
    chk("w_data",  drv_data_in, 32'hDEADBEEF);
    chk("w_we_re", 32'({drv_write_enable, drv_read_enable}), 32'h2);
    chk("w_pending_after_pop", 32'(pending), 0);
    get_rsp(200, lat, unst, ovl, rises);
    chk("w_cmd_stable", 32'(unst), 0);
    chk("w_start_busy_overlap", 32'(ovl), 1);
    chk("w_no_relaunch", 32'(rises), 0);
    check_rsp();
    tick();
    chk("w_rsp_consumed", 32'(rsp_valid), 0);

    // single read with one-cycle strobe
    busy_len = 10;
    push(1'b0, 8'h34, 32'h11111111);
    exp_q.push_back({1'b0, 8'h34, 32'hCAFEF00D, 1'b0});
    tick();
    chk("r_we_re", 32'({drv_write_enable, drv_read_enable}), 32'h1);
    get_rsp(200, lat, unst, ovl, rises);
    check_rsp();
    tick();

    // back-pressure and fill
    busy_len  = 3;
    rsp_ready = 1'b0;
    push(1'b1, 8'h40, 32'hA0A00001);
    exp_q.push_back({1'b1, 8'h40, 32'h0, 1'b0});
    get_rsp(200, lat, unst, ovl, rises);
    check_rsp();
    chk("bp_ready_b", 32'(req_ready), 1);
    push(1'b0, 8'h41, 32'h0);
    exp_q.push_back({1'b0, 8'h41, mdl_rdata(8'h41), 1'b0});
    push(1'b1, 8'h42, 32'hB0B00002);
    exp_q.push_back({1'b1, 8'h42, 32'h0, 1'b0});
    push(1'b0, 8'h43, 32'h0);
    exp_q.push_back({1'b0, 8'h43, mdl_rdata(8'h43), 1'b0});
    chk("bp_ready_e", 32'(req_ready), 1);
    push(1'b1, 8'h44, 32'hC0C00003);
    exp_q.push_back({1'b1, 8'h44, 32'h0, 1'b0});
    chk("full_pending", 32'(pending), 4);
    chk("full_ready_low", 32'(req_ready), 0);
    push(1'b1, 8'h99, 32'hFFFFFFFF);
    chk("full_refused", 32'(pending), 4);
    bad_fields = 0; starts_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!rsp_valid || !rsp_write || rsp_addr !== 8'h40 || rsp_rdata !== 32'h0 || rsp_timeout)
        bad_fields++;
      if (drv_start) starts_seen++;
    end
    chk("bp_rsp_stable", 32'(bad_fields), 0);
    chk("bp_no_start", 32'(starts_seen), 0);

    // drain in order
    rsp_ready = 1'b1;
    tick();
    chk("drain_rsp_dropped", 32'(rsp_valid), 0);
    tick();
    chk("drain_relaunch_2cyc", 32'(drv_start), 1);
    chk("drain_head_addr", 32'(drv_mem_address), 32'h41);
    chk("drain_pending", 32'(pending), 3);
    for (int i = 0; i < 4; i++) begin
      get_rsp(200, lat, unst, ovl, rises);
      check_rsp();
      chk("drain_pending_step", 32'(pending), 32'(3 - i));
    end

    // pointers past the wrap
    push(1'b0, 8'h45, 32'h0);
    exp_q.push_back({1'b0, 8'h45, mdl_rdata(8'h45), 1'b0});
    push(1'b1, 8'h46, 32'h46464646);
    exp_q.push_back({1'b1, 8'h46, 32'h0, 1'b0});
    get_rsp(200, lat, unst, ovl, rises);
    check_rsp();
    get_rsp(200, lat, unst, ovl, rises);
    check_rsp();
    chk("wrap_pending", 32'(pending), 0);

    // watchdog timeout with hung driver
    hang = 1'b1;
    push(1'b0, 8'h55, 32'h0);
    exp_q.push_back({1'b0, 8'h55, 32'h0, 1'b1});
    push(1'b1, 8'h66, 32'h66660000);
    get_rsp(300, lat, unst, ovl, rises);
    chk("to_latency", 32'(lat), TIMEOUT);
    check_rsp();
    tick();
    chk("to_rsp_dropped", 32'(rsp_valid), 0);
    tick();
    chk("to_next_launch", 32'(drv_start), 1);
    chk("to_next_addr", 32'(drv_mem_address), 32'h66);
    chk("to_next_we", 32'(drv_write_enable), 1);
    rst = 1'b1;
    hang = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // reset mid-operation with two queued
    busy_len = 30;
    push(1'b1, 8'h70, 32'h70707070);
    push(1'b0, 8'h71, 32'h0);
    push(1'b1, 8'h72, 32'h72727272);
    found_busy = 1'b0;
    for (int i = 0; i < 50 && !found_busy; i++) begin
      tick();
      if (drv_busy) found_busy = 1'b1;
    end
    chk("mid_busy_seen", 32'(found_busy), 1);
    tick();
    chk("mid_in_run", 32'(drv_start), 0);
    chk("mid_pending", 32'(pending), 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_pending", 32'(pending), 0);
    chk("mid_rst_start", 32'(drv_start), 0);
    chk("mid_rst_rsp", 32'(rsp_valid), 0);
    chk("mid_rst_ready", 32'(req_ready), 1);
    tick();
    tick();
    rst = 1'b0;
    rsp_seen = 0; starts_seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rsp_valid) rsp_seen++;
      if (drv_start) starts_seen++;
    end
    chk("mid_no_stale_rsp", 32'(rsp_seen), 0);
    chk("mid_no_stale_start", 32'(starts_seen), 0);

    // normal operation after reset
    busy_len = 5;
    push(1'b1, 8'h7F, 32'h7F7F7F7F);
    exp_q.push_back({1'b1, 8'h7F, 32'h0, 1'b0});
    get_rsp(200, lat, unst, ovl, rises);
    check_rsp();
    tick();
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
